// File: rtl/decoder_pkg.sv
// decoder_pkg: opcode constants, FSM state encoding and control-bundle type shared by the decode stage
package decoder_pkg;

  localparam int OPC_NOP = 0;
  localparam int OPC_LD  = 1;
  localparam int OPC_ST  = 2;
  localparam int OPC_ADD = 3;
  localparam int OPC_SUB = 4;
  localparam int OPC_AND = 5;
  localparam int OPC_OR  = 6;
  localparam int OPC_XOR = 7;
  localparam int OPC_NOT = 8;
  localparam int OPC_JMP = 9;
  localparam int OPC_JZ  = 10;
  localparam int OPC_LDX = 11;

  // First opcode value with no defined instruction.
  localparam int ILLEGAL_BASE = 12;

  typedef enum logic {
    S_OP  = 1'b0,
    S_EXT = 1'b1
  } state_t;

  typedef struct packed {
    logic st_ce;
    logic ld_ce;
    logic cy_ce;
    logic acc_ce;
    logic jmp;
    logic jz;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_lut.sv
// decode_lut: combinational opcode to control-enable mapping
//   opcode  in  OPC_W  opcode to decode
//   ctrl    out ctrl_t {st_ce, ld_ce, cy_ce, acc_ce, jmp, jz, illegal}
module decode_lut
  import decoder_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  logic [31:0] w_op;

  assign w_op = 32'(opcode);

  // Illegal codes fall through every equality test, so all other enables stay 0.
  // Jumps intentionally leave acc_ce low.
  assign ctrl = '{
    st_ce:   w_op == OPC_ST,
    ld_ce:   w_op == OPC_LD || w_op == OPC_LDX,
    cy_ce:   w_op == OPC_ADD || w_op == OPC_SUB,
    acc_ce:  w_op == OPC_LD || w_op == OPC_LDX || (w_op >= OPC_ADD && w_op <= OPC_NOT),
    jmp:     w_op == OPC_JMP,
    jz:      w_op == OPC_JZ,
    illegal: w_op >= ILLEGAL_BASE
  };

endmodule

// File: rtl/id_pipe.sv
// id_pipe: registered instruction-decode stage with valid/ready handshakes and two-word LDX
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous kill of held output and partial LDX
//   in_valid/in_ready/in_instr  fetch-side handshake and instruction word
//   out_valid/out_ready         execute-side handshake
//   out_opcode/out_reg/out_imm  decoded fields (imm = zero-extended arg, or LDX second word)
//   st_ce..illegal              registered control enables, meaningful only with out_valid
module id_pipe
  import decoder_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4,
  parameter int ARG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_reg,
  output logic [INSTR_W-1:0] out_imm,
  output logic               st_ce,
  output logic               ld_ce,
  output logic               cy_ce,
  output logic               acc_ce,
  output logic               jmp,
  output logic               jz,
  output logic               illegal
);

  localparam int REG_LSB = INSTR_W - OPC_W - REG_W;

  logic [OPC_W-1:0]   w_opc;
  logic [OPC_W-1:0]   w_lut_opc;
  logic [REG_W-1:0]   w_reg;
  logic               w_accept;
  logic               w_is_ldx;
  ctrl_t              w_ctrl;

  state_t             r_state;
  logic [REG_W-1:0]   r_ldx_reg;
  logic               r_valid;
  logic [OPC_W-1:0]   r_opcode;
  logic [REG_W-1:0]   r_reg;
  logic [INSTR_W-1:0] r_imm;
  ctrl_t              r_ctrl;

  assign w_opc    = in_instr[INSTR_W-1 -: OPC_W];
  assign w_reg    = in_instr[REG_LSB +: REG_W];
  assign w_is_ldx = w_opc == OPC_W'(OPC_LDX);

  // The LDX immediate word carries no opcode, so decode the remembered LDX instead.
  assign w_lut_opc = (r_state == S_EXT) ? OPC_W'(OPC_LDX) : w_opc;

  decode_lut #(.OPC_W(OPC_W)) u_lut (
    .opcode (w_lut_opc),
    .ctrl   (w_ctrl)
  );

  // No skid buffer: ready follows out_ready combinationally; held low in reset and flush.
  assign in_ready = rst_n && !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OP;
      r_ldx_reg <= '0;
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_reg     <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
    end else if (flush) begin
      r_state   <= S_OP;
      r_ldx_reg <= '0;
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_EXT) begin
        r_state  <= S_OP;
        r_valid  <= 1'b1;
        r_opcode <= OPC_W'(OPC_LDX);
        r_reg    <= r_ldx_reg;
        r_imm    <= in_instr;
        r_ctrl   <= w_ctrl;
      end else if (w_is_ldx) begin
        // First LDX word: any held output was consumed this cycle, nothing new yet.
        r_state   <= S_EXT;
        r_ldx_reg <= w_reg;
        r_valid   <= 1'b0;
      end else begin
        r_valid  <= 1'b1;
        r_opcode <= w_opc;
        r_reg    <= w_reg;
        r_imm    <= INSTR_W'(in_instr[ARG_W-1:0]);
        r_ctrl   <= w_ctrl;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_opcode = r_opcode;
  assign out_reg    = r_reg;
  assign out_imm    = r_imm;
  assign {st_ce, ld_ce, cy_ce, acc_ce, jmp, jz, illegal} = r_ctrl;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: table vectors, directed corner sequences and randomized traffic against a transaction model
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode;
  logic [3:0]  out_reg;
  logic [15:0] out_imm;
  logic        st_ce, ld_ce, cy_ce, acc_ce, jmp, jz, illegal;
  logic [6:0]  w_ctl;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  opc;
    logic [3:0]  rg;
    logic [15:0] imm;
    logic [6:0]  ctrl;
  } rec_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  opc;
    logic [3:0]  rg;
    logic [15:0] imm;
    logic [6:0]  ctrl;
  } vec_t;

  rec_t       q[$];
  bit         pend = 1'b0;
  logic [3:0] pend_reg = '0;
  vec_t       tbl[13];

  always #5 clk = ~clk;

  assign w_ctl = {st_ce, ld_ce, cy_ce, acc_ce, jmp, jz, illegal};

  id_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_reg    (out_reg),
    .out_imm    (out_imm),
    .st_ce      (st_ce),
    .ld_ce      (ld_ce),
    .cy_ce      (cy_ce),
    .acc_ce     (acc_ce),
    .jmp        (jmp),
    .jz         (jz),
    .illegal    (illegal)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Control bits {st, ld, cy, acc, jmp, jz, illegal} from the opcode table.
  function automatic logic [6:0] ctrl_of(input int op);
    logic [6:0] c;
    c[6] = op == 2;
    c[5] = op inside {1, 11};
    c[4] = op inside {3, 4};
    c[3] = op inside {1, 3, 4, 5, 6, 7, 8, 11};
    c[2] = op == 9;
    c[1] = op == 10;
    c[0] = op >= 12;
    return c;
  endfunction

  function automatic rec_t mk(input logic [3:0] op, input logic [3:0] rg, input logic [15:0] imm);
    rec_t r;
    r.opc  = op;
    r.rg   = rg;
    r.imm  = imm;
    r.ctrl = ctrl_of(int'(op));
    return r;
  endfunction

  // One clock: drive, check against the model just before the edge, advance the model.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
    bit mready;
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    #2;
    mready = !fl && (q.size() == 0 || rdy);
    chk("in_ready", 32'(in_ready), 32'(mready));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0 && out_valid) begin
      chk("m_opcode", 32'(out_opcode), 32'(q[0].opc));
      chk("m_reg", 32'(out_reg), 32'(q[0].rg));
      chk("m_imm", 32'(out_imm), 32'(q[0].imm));
      chk("m_ctrl", 32'(w_ctl), 32'(q[0].ctrl));
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (v && mready) begin
        if (pend) begin
          q.push_back(mk(4'd11, pend_reg, ins));
          pend = 1'b0;
        end else if (ins[15:12] == 4'd11) begin
          pend     = 1'b1;
          pend_reg = ins[11:8];
        end else begin
          q.push_back(mk(ins[15:12], ins[11:8], {8'h00, ins[7:0]}));
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{16'h3234, 4'd3,  4'd2,  16'h0034, 7'b0011000};
    tbl[1]  = '{16'h2100, 4'd2,  4'd1,  16'h0000, 7'b1000000};
    tbl[2]  = '{16'h1A7F, 4'd1,  4'd10, 16'h007F, 7'b0101000};
    tbl[3]  = '{16'h4000, 4'd4,  4'd0,  16'h0000, 7'b0011000};
    tbl[4]  = '{16'h9010, 4'd9,  4'd0,  16'h0010, 7'b0000100};
    tbl[5]  = '{16'hA3FF, 4'd10, 4'd3,  16'h00FF, 7'b0000010};
    tbl[6]  = '{16'h0000, 4'd0,  4'd0,  16'h0000, 7'b0000000};
    tbl[7]  = '{16'h8C01, 4'd8,  4'd12, 16'h0001, 7'b0001000};
    tbl[8]  = '{16'hF0AA, 4'd15, 4'd0,  16'h00AA, 7'b0000001};
    tbl[9]  = '{16'hC123, 4'd12, 4'd1,  16'h0023, 7'b0000001};
    tbl[10] = '{16'h5F55, 4'd5,  4'd15, 16'h0055, 7'b0001000};
    tbl[11] = '{16'h7E81, 4'd7,  4'd14, 16'h0081, 7'b0001000};
    tbl[12] = '{16'h6012, 4'd6,  4'd0,  16'h0012, 7'b0001000};

    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_opcode", 32'(out_opcode), 32'd0);
    chk("rst_imm", 32'(out_imm), 32'd0);
    chk("rst_ctrl", 32'(w_ctl), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].instr, 1'b1, 1'b0);
      #1;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_opcode", 32'(out_opcode), 32'(tbl[i].opc));
      chk("tbl_reg", 32'(out_reg), 32'(tbl[i].rg));
      chk("tbl_imm", 32'(out_imm), 32'(tbl[i].imm));
      chk("tbl_ctrl", 32'(w_ctl), 32'(tbl[i].ctrl));
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // LDX: no output after the first word, one output after the second.
    cycle(1'b1, 16'hB500, 1'b1, 1'b0);
    chk("ldx_first_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("ldx_valid", 32'(out_valid), 32'd1);
    chk("ldx_opcode", 32'(out_opcode), 32'd11);
    chk("ldx_reg", 32'(out_reg), 32'd5);
    chk("ldx_imm", 32'(out_imm), 32'hBEEF);
    chk("ldx_ctrl", 32'(w_ctl), 32'b0101000);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("ldx_once", 32'(out_valid), 32'd0);

    // Stall: ST held while SUB waits.
    cycle(1'b1, 16'h2100, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 16'h4000, 1'b0, 1'b0);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_opcode", 32'(out_opcode), 32'd2);
      chk("stall_reg", 32'(out_reg), 32'd1);
      chk("stall_ctrl", 32'(w_ctl), 32'b1000000);
    end
    cycle(1'b1, 16'h4000, 1'b1, 1'b0);
    chk("stall_sub_valid", 32'(out_valid), 32'd1);
    chk("stall_sub_opcode", 32'(out_opcode), 32'd4);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("stall_no_dup", 32'(out_valid), 32'd0);

    // Flush mid-LDX; the word offered with flush must be re-presented.
    cycle(1'b1, 16'hB700, 1'b1, 1'b0);
    cycle(1'b1, 16'h9010, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 16'h9010, 1'b1, 1'b0);
    chk("flush_jmp_opcode", 32'(out_opcode), 32'd9);
    chk("flush_jmp_ctrl", 32'(w_ctl), 32'b0000100);
    chk("flush_jmp_imm", 32'(out_imm), 32'h0010);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset while in S_EXT.
    cycle(1'b1, 16'h3234, 1'b1, 1'b0);
    cycle(1'b1, 16'hB500, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_opcode", 32'(out_opcode), 32'd0);
    chk("arst_reg", 32'(out_reg), 32'd0);
    chk("arst_imm", 32'(out_imm), 32'd0);
    chk("arst_ctrl", 32'(w_ctl), 32'd0);
    q.delete();
    pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h3234, 1'b1, 1'b0);
    chk("arst_add_opcode", 32'(out_opcode), 32'd3);
    chk("arst_add_ctrl", 32'(w_ctl), 32'b0011000);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic with LDX-heavy opcode mix.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hB;
      cycle(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
